// File: rtl/lc3_pkg.sv
// Constants and types shared by the LC-3 memory controller and the LC-3 core:
// memory-mapped register addresses, the boot-sequencer states and opcodes.
package lc3_pkg;

    // Console and keyboard registers in the xFE00 page
    localparam logic [15:0] KBSR_ADDR = 16'hFE00;
    localparam logic [15:0] KBDR_ADDR = 16'hFE02;
    localparam logic [15:0] DSR_ADDR  = 16'hFE04;
    localparam logic [15:0] DDR_ADDR  = 16'hFE06;

    // address[15:9] of every location in the MMIO page (xFE00-xFFFF)
    localparam logic [6:0] MMIO_PAGE = 7'h7F;

    // Boot sequencer: stream the image in, hold the core one more cycle, then run
    typedef enum logic [1:0] {
        ST_BOOT    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } boot_state_e;

    // LC-3 opcodes (instruction bits [15:12])
    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_RTI  = 4'b1000;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_RES  = 4'b1101;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    // True when a core address falls in the memory-mapped register page
    function automatic logic is_mmio(input logic [15:0] addr);
        return addr[15:9] == MMIO_PAGE;
    endfunction

endpackage

// File: rtl/lc3_ram.sv
// Word-addressed 16-bit RAM: one synchronous write port, one asynchronous
// read port. Contents are not reset so a program survives a controller reset.
module lc3_ram #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [15:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [15:0]       rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [15:0] mem [DEPTH];

    // Write takes effect at the rising edge; read sees it the following cycle
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/lc3_mem_ctrl.sv
// LC-3 memory controller: owns the program/data RAM, serves the core's
// single-port bus, maps the console display registers at xFE04/xFE06 and
// boot-loads a program image while holding the core in reset.
module lc3_mem_ctrl #(
    parameter int          ADDR_W    = 12,
    parameter logic [15:0] LOAD_BASE = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        cpu_reset,
    input  logic        writeEnable,
    input  logic [15:0] address,
    input  logic [15:0] dataToMemory,
    output logic [15:0] dataFromMemory,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] load_data,
    input  logic        load_last,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_overflow
);

    import lc3_pkg::*;

    boot_state_e       state_q;
    logic              cpu_reset_q;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              tx_valid_q, tx_valid_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_overflow_q, tx_overflow_d;

    logic              load_fire;
    logic              core_we;
    logic              addr_mmio;
    logic              ddr_wr;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [15:0]       ram_wdata;
    logic [15:0]       ram_rdata;

    // load_ready is a pure decode of the boot state, gated by the reset pin so
    // it drops the instant reset is asserted and is high in every BOOT cycle.
    assign load_ready = reset && (state_q == ST_BOOT);
    assign load_fire  = load_ready && load_valid;

    // The core only writes once it is out of reset, i.e. in RUN
    assign core_we   = writeEnable && (state_q == ST_RUN);
    assign addr_mmio = is_mmio(address);
    assign ddr_wr    = core_we && (address == DDR_ADDR);

    // Boot sequencer; cpu_reset is registered from the state so it trails RUN by one edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_BOOT;
            cpu_reset_q <= 1'b1;
        end else begin
            cpu_reset_q <= (state_q != ST_RUN);
            case (state_q)
                ST_BOOT: begin
                    if (load_fire && load_last) begin
                        state_q <= ST_RELEASE;
                    end
                end
                ST_RELEASE: state_q <= ST_RUN;
                ST_RUN:     state_q <= ST_RUN;
                default:    state_q <= ST_BOOT;
            endcase
        end
    end

    // Loader write pointer: advances per accepted image word, wraps modulo depth
    always_comb begin
        ptr_d = ptr_q;
        if (load_fire) begin
            ptr_d = ptr_q + 1'b1;
        end
    end

    // Single RAM write port: loader owns it in BOOT, the core in RUN (never MMIO)
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = ptr_q;
        ram_wdata = load_data;
        if (load_fire) begin
            ram_we = 1'b1;
        end else if (core_we && !addr_mmio) begin
            ram_we    = 1'b1;
            ram_waddr = address[ADDR_W-1:0];
            ram_wdata = dataToMemory;
        end
    end

    // Console display: a DDR write is accepted if the slot is free or being
    // drained on this same edge; otherwise it is dropped and flagged sticky.
    always_comb begin
        tx_valid_d    = tx_valid_q;
        tx_data_d     = tx_data_q;
        tx_overflow_d = tx_overflow_q;
        if (tx_valid_q && tx_ready) begin
            tx_valid_d = 1'b0;
        end
        if (ddr_wr) begin
            if (!tx_valid_q || tx_ready) begin
                tx_valid_d = 1'b1;
                tx_data_d  = dataToMemory[7:0];
            end else begin
                tx_overflow_d = 1'b1;
            end
        end
    end

    // Loader pointer and console state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q         <= LOAD_BASE[ADDR_W-1:0];
            tx_valid_q    <= 1'b0;
            tx_data_q     <= 8'h00;
            tx_overflow_q <= 1'b0;
        end else begin
            ptr_q         <= ptr_d;
            tx_valid_q    <= tx_valid_d;
            tx_data_q     <= tx_data_d;
            tx_overflow_q <= tx_overflow_d;
        end
    end

    // Read mux: RAM with upper address bits aliased, or the MMIO registers
    always_comb begin
        dataFromMemory = ram_rdata;
        if (addr_mmio) begin
            case (address)
                DSR_ADDR: dataFromMemory = {~tx_valid_q, 15'b0};
                DDR_ADDR: dataFromMemory = {8'h00, tx_data_q};
                default:  dataFromMemory = 16'h0000;
            endcase
        end
    end

    lc3_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (address[ADDR_W-1:0]),
        .rdata (ram_rdata)
    );

    assign cpu_reset   = cpu_reset_q;
    assign tx_valid    = tx_valid_q;
    assign tx_data     = tx_data_q;
    assign tx_overflow = tx_overflow_q;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Bench for lc3_mem_ctrl. Two instances share every input: u_dut uses
// LOAD_BASE=x0000, u_dut_w uses LOAD_BASE=x0FFE to exercise pointer wrap.
module tb_lc3_mem_ctrl;

    logic        clk;
    logic        reset;
    logic        writeEnable;
    logic [15:0] address;
    logic [15:0] dataToMemory;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_last;
    logic        tx_ready;

    logic        cpu_reset,   cpu_reset_w;
    logic [15:0] dfm,         dfm_w;
    logic        load_ready,  load_ready_w;
    logic        tx_valid,    tx_valid_w;
    logic [7:0]  tx_data,     tx_data_w;
    logic        tx_overflow, tx_overflow_w;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
    } sb_t;

    sb_t         sb0[$];
    sb_t         sb1[$];
    logic [7:0]  txq[$];
    logic [15:0] ptr0, ptr1;

    lc3_mem_ctrl #(.ADDR_W(12), .LOAD_BASE(16'h0000)) u_dut (
        .clk(clk), .reset(reset), .cpu_reset(cpu_reset),
        .writeEnable(writeEnable), .address(address), .dataToMemory(dataToMemory),
        .dataFromMemory(dfm), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_last(load_last), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_data(tx_data), .tx_overflow(tx_overflow)
    );

    lc3_mem_ctrl #(.ADDR_W(12), .LOAD_BASE(16'h0FFE)) u_dut_w (
        .clk(clk), .reset(reset), .cpu_reset(cpu_reset_w),
        .writeEnable(writeEnable), .address(address), .dataToMemory(dataToMemory),
        .dataFromMemory(dfm_w), .load_valid(load_valid), .load_ready(load_ready_w),
        .load_data(load_data), .load_last(load_last), .tx_valid(tx_valid_w),
        .tx_ready(tx_ready), .tx_data(tx_data_w), .tx_overflow(tx_overflow_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    // Console scoreboard: every byte handed over must be the next expected byte
    always @(posedge clk) begin
        if (reset === 1'b1 && tx_valid === 1'b1 && tx_ready === 1'b1) begin
            checks++;
            if (txq.size() == 0) begin
                errors++;
                $display("FAIL tx_unexpected: got byte %h, expected none", tx_data);
            end else begin
                logic [7:0] exp_b;
                exp_b = txq.pop_front();
                if (tx_data !== exp_b) begin
                    errors++;
                    $display("FAIL tx_byte: got %h, expected %h", tx_data, exp_b);
                end
            end
        end
    end

    // Assert reset asynchronously mid-cycle and check outputs at once
    task automatic do_reset(input string tag);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++; if (cpu_reset !== 1'b1)   begin errors++; $display("FAIL %s cpu_reset: got %b, expected 1", tag, cpu_reset); end
        checks++; if (load_ready !== 1'b0)  begin errors++; $display("FAIL %s load_ready: got %b, expected 0", tag, load_ready); end
        checks++; if (tx_valid !== 1'b0)    begin errors++; $display("FAIL %s tx_valid: got %b, expected 0", tag, tx_valid); end
        checks++; if (tx_data !== 8'h00)    begin errors++; $display("FAIL %s tx_data: got %h, expected 00", tag, tx_data); end
        checks++; if (tx_overflow !== 1'b0) begin errors++; $display("FAIL %s tx_overflow: got %b, expected 0", tag, tx_overflow); end
        checks++; if (cpu_reset_w !== 1'b1) begin errors++; $display("FAIL %s cpu_reset_w: got %b, expected 1", tag, cpu_reset_w); end
        sb0.delete();
        sb1.delete();
        ptr0 = 16'h0000;
        ptr1 = 16'h0FFE;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++; if (load_ready !== 1'b1) begin errors++; $display("FAIL %s load_ready_after: got %b, expected 1", tag, load_ready); end
    endtask

    task automatic load_word(input logic [15:0] d, input logic last);
        sb_t e;
        @(negedge clk);
        load_valid = 1'b1;
        load_data  = d;
        load_last  = last;
        #1;
        checks++;
        if (load_ready !== 1'b1) begin
            errors++;
            $display("FAIL load_ready_boot: got %b, expected 1", load_ready);
        end
        e.addr = ptr0; e.data = d; sb0.push_back(e);
        e.addr = ptr1; e.data = d; sb1.push_back(e);
        ptr0 = (ptr0 + 16'd1) & 16'h0FFF;
        ptr1 = (ptr1 + 16'd1) & 16'h0FFF;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic wait_run;
        for (int i = 0; i < 10; i++) begin
            if (cpu_reset === 1'b0) break;
            @(posedge clk);
            #1;
        end
        checks++;
        if (cpu_reset !== 1'b0 || cpu_reset_w !== 1'b0) begin
            errors++;
            $display("FAIL wait_run: cpu_reset %b / %b, expected 0 / 0", cpu_reset, cpu_reset_w);
        end
    endtask

    // Drain both loader scoreboards through the core read port
    task automatic check_ram(input string tag);
        sb_t e;
        while (sb0.size() > 0) begin
            e = sb0.pop_front();
            @(negedge clk); address = e.addr; #1;
            checks++;
            if (dfm !== e.data) begin
                errors++;
                $display("FAIL %s ram[%h]: got %h, expected %h", tag, e.addr, dfm, e.data);
            end
        end
        while (sb1.size() > 0) begin
            e = sb1.pop_front();
            @(negedge clk); address = e.addr; #1;
            checks++;
            if (dfm_w !== e.data) begin
                errors++;
                $display("FAIL %s wrap_ram[%h]: got %h, expected %h", tag, e.addr, dfm_w, e.data);
            end
        end
    endtask

    task automatic core_write(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        address      = a;
        dataToMemory = d;
        writeEnable  = 1'b1;
        @(posedge clk);
        #1;
        writeEnable = 1'b0;
    endtask

    task automatic core_read(input logic [15:0] a, output logic [15:0] d);
        @(negedge clk);
        address = a;
        #1;
        d = dfm;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        reset = 1'b1;
        do_reset("reset");
    endtask

    task automatic test_load;
        load_word(16'h1021, 1'b0);
        load_word(16'h1262, 1'b0);
        load_word(16'hF025, 1'b1);
        checks++; if (cpu_reset !== 1'b1)  begin errors++; $display("FAIL load cpu_reset_e0: got %b, expected 1", cpu_reset); end
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL load load_ready_rel: got %b, expected 0", load_ready); end
        @(posedge clk); #1;
        checks++; if (cpu_reset !== 1'b1)  begin errors++; $display("FAIL load cpu_reset_e1: got %b, expected 1", cpu_reset); end
        @(posedge clk); #1;
        checks++; if (cpu_reset !== 1'b0)  begin errors++; $display("FAIL load cpu_reset_e2: got %b, expected 0", cpu_reset); end
        checks++; if (load_ready !== 1'b0) begin errors++; $display("FAIL load load_ready_run: got %b, expected 0", load_ready); end
        check_ram("load");
    endtask

    task automatic test_ram_rw;
        logic [15:0] r;
        core_write(16'h0010, 16'h1234);
        core_read(16'h0010, r);
        checks++; if (r !== 16'h1234) begin errors++; $display("FAIL ram_rw: got %h, expected 1234", r); end
        core_read(16'h1010, r);
        checks++; if (r !== 16'h1234) begin errors++; $display("FAIL ram_alias: got %h, expected 1234", r); end
    endtask

    task automatic test_console;
        logic [15:0] r;
        tx_ready = 1'b0;
        core_write(16'hFE06, 16'h0041);
        txq.push_back(8'h41);
        checks++; if (tx_valid !== 1'b1)    begin errors++; $display("FAIL con tx_valid: got %b, expected 1", tx_valid); end
        checks++; if (tx_data !== 8'h41)    begin errors++; $display("FAIL con tx_data: got %h, expected 41", tx_data); end
        checks++; if (tx_overflow !== 1'b0) begin errors++; $display("FAIL con ovf0: got %b, expected 0", tx_overflow); end
        core_read(16'hFE04, r);
        checks++; if (r !== 16'h0000) begin errors++; $display("FAIL con dsr_busy: got %h, expected 0000", r); end
        core_read(16'hFE06, r);
        checks++; if (r !== 16'h0041) begin errors++; $display("FAIL con ddr_read: got %h, expected 0041", r); end
        core_write(16'hFE06, 16'h0042);
        checks++; if (tx_overflow !== 1'b1) begin errors++; $display("FAIL con ovf1: got %b, expected 1", tx_overflow); end
        checks++; if (tx_data !== 8'h41)    begin errors++; $display("FAIL con tx_data_kept: got %h, expected 41", tx_data); end
        @(negedge clk); tx_ready = 1'b1;
        @(posedge clk); #1; tx_ready = 1'b0;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL con tx_drain: got %b, expected 0", tx_valid); end
        core_read(16'hFE04, r);
        checks++; if (r !== 16'h8000) begin errors++; $display("FAIL con dsr_idle: got %h, expected 8000", r); end
    endtask

    task automatic test_mmio_ignore;
        logic [15:0] r;
        core_write(16'h0E04, 16'h5A5A);
        core_write(16'h0E10, 16'hA5A5);
        core_write(16'hFE04, 16'hBEEF);
        core_write(16'hFE10, 16'hBEEF);
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL mmio tx_valid: got %b, expected 0", tx_valid); end
        checks++; if (tx_data !== 8'h41) begin errors++; $display("FAIL mmio tx_data: got %h, expected 41", tx_data); end
        core_read(16'hFE04, r);
        checks++; if (r !== 16'h8000) begin errors++; $display("FAIL mmio dsr: got %h, expected 8000", r); end
        core_read(16'hFE10, r);
        checks++; if (r !== 16'h0000) begin errors++; $display("FAIL mmio other: got %h, expected 0000", r); end
        core_read(16'h0E04, r);
        checks++; if (r !== 16'h5A5A) begin errors++; $display("FAIL mmio ram_e04: got %h, expected 5a5a", r); end
        core_read(16'h0E10, r);
        checks++; if (r !== 16'hA5A5) begin errors++; $display("FAIL mmio ram_e10: got %h, expected a5a5", r); end
    endtask

    task automatic test_reset_midload;
        do_reset("run_reset");
        load_word(16'hAAAA, 1'b0);
        load_word(16'hBBBB, 1'b0);
        do_reset("load_reset");
        load_word(16'hC001, 1'b0);
        load_word(16'hC002, 1'b0);
        load_word(16'hC003, 1'b0);
        load_word(16'hC004, 1'b1);
        wait_run();
        check_ram("reload");
    endtask

    task automatic test_back_to_back;
        tx_ready = 1'b0;
        core_write(16'hFE06, 16'h0055);
        txq.push_back(8'h55);
        checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL b2b tx_valid0: got %b, expected 1", tx_valid); end
        @(negedge clk);
        address      = 16'hFE06;
        dataToMemory = 16'h0066;
        writeEnable  = 1'b1;
        tx_ready     = 1'b1;
        txq.push_back(8'h66);
        @(posedge clk); #1;
        writeEnable = 1'b0;
        tx_ready    = 1'b0;
        checks++; if (tx_valid !== 1'b1)    begin errors++; $display("FAIL b2b tx_valid1: got %b, expected 1", tx_valid); end
        checks++; if (tx_data !== 8'h66)    begin errors++; $display("FAIL b2b tx_data: got %h, expected 66", tx_data); end
        checks++; if (tx_overflow !== 1'b0) begin errors++; $display("FAIL b2b ovf: got %b, expected 0", tx_overflow); end
        @(negedge clk); tx_ready = 1'b1;
        @(posedge clk); #1; tx_ready = 1'b0;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL b2b drain: got %b, expected 0", tx_valid); end
        checks++; if (txq.size() != 0)   begin errors++; $display("FAIL b2b txq_left: got %0d, expected 0", txq.size()); end
    endtask

    initial begin
        reset        = 1'b0;
        writeEnable  = 1'b0;
        address      = 16'h0000;
        dataToMemory = 16'h0000;
        load_valid   = 1'b0;
        load_data    = 16'h0000;
        load_last    = 1'b0;
        tx_ready     = 1'b0;
        ptr0         = 16'h0000;
        ptr1         = 16'h0FFE;

        test_reset();
        test_load();
        test_ram_rw();
        test_console();
        test_mmio_ignore();
        test_reset_midload();
        test_back_to_back();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
